quadrature_generator: RTL and testbench



---
 rtl/quadrature_generator_pkg.sv | 17 +
 rtl/quadrature_generator_quad_phase_seq.sv | 48 ++++
 rtl/quadrature_generator.sv | 96 +++++++++
 tb/tb_quadrature_generator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/quadrature_generator_pkg.sv
// Shared phase encodings and register map for the quadrature generator.
package quadrature_generator_pkg;

    localparam int STEPS_W = 16;

    // Phase values are the literal {a,b} output levels.
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_t;

    localparam logic ADDR_STEPS  = 1'b0;
    localparam logic ADDR_PERIOD = 1'b1;

endpackage

// File: rtl/quadrature_generator_quad_phase_seq.sv
// Four-phase quadrature state machine; one tick moves one Gray-code transition.
module quad_phase_seq
    import quadrature_generator_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic dir,
    output logic a,
    output logic b,
    output logic cycle_end,
    output logic cycle_dir
);

    phase_t phase, phase_next;
    logic   dir_q, dir_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH_00;
            dir_q <= 1'b0;
        end else begin
            phase <= phase_next;
            dir_q <= dir_next;
        end
    end

    // Direction is sampled only when leaving 00, so a cycle in flight never reverses.
    always_comb begin
        phase_next = phase;
        dir_next   = dir_q;
        cycle_dir  = (phase == PH_00) ? dir : dir_q;
        cycle_end  = 1'b0;
        if (tick) begin
            if (phase == PH_00) dir_next = dir;
            unique case (phase)
                PH_00: phase_next = cycle_dir ? PH_10 : PH_01;
                PH_01: phase_next = cycle_dir ? PH_00 : PH_11;
                PH_11: phase_next = cycle_dir ? PH_01 : PH_10;
                PH_10: phase_next = cycle_dir ? PH_11 : PH_00;
            endcase
            cycle_end = (phase != PH_00) && (phase_next == PH_00);
        end
    end

    assign {a, b} = phase;

endmodule

// File: rtl/quadrature_generator.sv
// Memory-mapped quadrature waveform generator: a signed step count is played out as
// full A/B cycles, one phase transition every PERIOD clocks.
module quadrature_generator
    import quadrature_generator_pkg::*;
#(
    parameter int                  PERIOD_W       = 16,
    parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 16'd50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               write,
    input  logic               addr,
    input  logic [STEPS_W-1:0] writedata,
    output logic [STEPS_W-1:0] readdata,
    output logic               quad_a,
    output logic               quad_b,
    output logic               busy,
    output logic               done
);

    localparam logic signed [STEPS_W-1:0] ONE = STEPS_W'(1);

    logic [PERIOD_W-1:0]       period;
    logic [PERIOD_W-1:0]       div_cnt;
    logic [PERIOD_W-1:0]       div_lim;
    logic [PERIOD_W-1:0]       eff_lim;
    logic signed [STEPS_W-1:0] remaining;
    logic                      busy_q;
    logic                      wr_steps, wr_period;
    logic                      tick, cycle_end, cycle_dir;

    function automatic logic signed [STEPS_W-1:0] step_toward_zero(
        input logic signed [STEPS_W-1:0] v
    );
        return v[STEPS_W-1] ? v + ONE : v - ONE;
    endfunction

    assign wr_steps  = en && write && (addr == ADDR_STEPS);
    assign wr_period = en && write && (addr == ADDR_PERIOD);
    assign eff_lim   = (period == '0) ? '0 : period - 1'b1;
    assign busy      = (remaining != '0) || ({quad_a, quad_b} != PH_00);
    assign tick      = busy && (div_cnt == div_lim);
    assign done      = busy_q && !busy;

    always_comb begin
        readdata = remaining;
        if (addr == ADDR_PERIOD) readdata = STEPS_W'(period);
    end

    quad_phase_seq u_seq (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .dir       (remaining[STEPS_W-1]),
        .a         (quad_a),
        .b         (quad_b),
        .cycle_end (cycle_end),
        .cycle_dir (cycle_dir)
    );

    // The reload limit is captured only at reload or while idle, so a PERIOD
    // write never disturbs the count already in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            period  <= DEFAULT_PERIOD;
            div_cnt <= '0;
            div_lim <= '0;
        end else begin
            if (wr_period) period <= writedata[PERIOD_W-1:0];
            if (!busy || tick) begin
                div_cnt <= '0;
                div_lim <= eff_lim;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // A write on the completion clock wins over the decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= busy;
            if (wr_steps) begin
                remaining <= signed'(writedata);
            end else if (cycle_end && (remaining != '0) &&
                         (remaining[STEPS_W-1] == cycle_dir)) begin
                remaining <= step_toward_zero(remaining);
            end
        end
    end

endmodule

// File: tb/tb_quadrature_generator.sv
// Scoreboard bench: stimulus queues expected {a,b} transitions, a monitor checks them.
module tb_quadrature_generator;
    import quadrature_generator_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        write = 1'b0;
    logic        addr = 1'b0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        quad_a, quad_b, busy, done;

    quadrature_generator #(.PERIOD_W(16), .DEFAULT_PERIOD(16'd50)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .write     (write),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .quad_a    (quad_a),
        .quad_b    (quad_b),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ab;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         done_cnt = 0;
    int         dec_cnt = 0;
    int         w_edge = 0;
    logic [1:0] last_ab = 2'b00;
    logic [1:0] mon_ab;
    exp_t       mon_e;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every change of {a,b} is matched against the head of the queue.
    always @(negedge clk) begin
        mon_ab = {quad_a, quad_b};
        if (done === 1'b1) done_cnt++;
        if (!$isunknown(mon_ab) && mon_ab !== last_ab) begin
            if (exp_q.size() == 0) begin
                check("unexpected transition", 32'(mon_ab), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("phase value", 32'(mon_ab), 32'(mon_e.ab));
                if (mon_e.cyc >= 0) check("phase timing", 32'(cyc), 32'(mon_e.cyc));
            end
            if (last_ab == 2'b10 && mon_ab == 2'b00) dec_cnt++;
            if (last_ab == 2'b01 && mon_ab == 2'b00) dec_cnt--;
            last_ab = mon_ab;
        end
    end

    task automatic push_ab(input logic [1:0] ab, input int c);
        exp_t e;
        e.ab  = ab;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // One full cycle; gap < 0 leaves the timing unchecked.
    task automatic push_cycle(input logic rev, input int t0, input int gap);
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] ab;
            case (k)
                1:       ab = rev ? 2'b10 : 2'b01;
                2:       ab = 2'b11;
                3:       ab = rev ? 2'b01 : 2'b10;
                default: ab = 2'b00;
            endcase
            push_ab(ab, (gap < 0) ? -1 : t0 + k * gap);
        end
    endtask

    task automatic wr(input logic a, input logic [15:0] d);
        @(posedge clk); #1;
        en = 1'b1; write = 1'b1; addr = a; writedata = d;
        @(posedge clk); #1;
        en = 1'b0; write = 1'b0;
        w_edge = cyc;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 50000", cyc);
        $fatal(1);
    end

    initial begin
        int w, n, d0, dec0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset quad_a", 32'(quad_a), 32'd0);
        check("reset quad_b", 32'(quad_b), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        addr = ADDR_PERIOD; #1;
        check("reset period", 32'(readdata), 32'd50);
        addr = ADDR_STEPS; #1;
        check("reset remaining", 32'(readdata), 32'd0);

        // PERIOD=4, STEPS=+2
        wr(ADDR_PERIOD, 16'd4);
        d0 = done_cnt;
        wr(ADDR_STEPS, 16'd2);
        w = w_edge;
        push_cycle(1'b0, w, 4);
        push_cycle(1'b0, w + 16, 4);
        n = 0;
        while (busy && n < 100) begin
            if (n == 5)  check("t2 remaining first cycle", 32'(readdata), 32'd2);
            if (n == 17) check("t2 remaining second cycle", 32'(readdata), 32'd1);
            @(posedge clk); #1;
            n++;
        end
        check("t2 busy span", 32'(n), 32'd32);
        check("t2 done pulse", 32'(done), 32'd1);
        check("t2 remaining end", 32'(readdata), 32'd0);
        @(posedge clk); #1;
        check("t2 done width", 32'(done), 32'd0);
        check("t2 done count", 32'(done_cnt - d0), 32'd1);

        // PERIOD=0, STEPS=-1
        wr(ADDR_PERIOD, 16'd0);
        wr(ADDR_STEPS, 16'hFFFF);
        push_cycle(1'b1, w_edge, 1);
        wait_idle("t3 idle", 20);
        check("t3 remaining end", 32'(readdata), 32'd0);

        // Loopback decoder, PERIOD=8: +5 then -3
        wr(ADDR_PERIOD, 16'd8);
        dec0 = dec_cnt;
        wr(ADDR_STEPS, 16'd5);
        for (int i = 0; i < 5; i++) push_cycle(1'b0, 0, -1);
        wait_idle("t4 fwd idle", 400);
        @(posedge clk); #1;
        check("t4 decoder +5", 32'(dec_cnt - dec0), 32'd5);
        wr(ADDR_STEPS, 16'hFFFD);
        for (int i = 0; i < 3; i++) push_cycle(1'b1, 0, -1);
        wait_idle("t4 rev idle", 300);
        @(posedge clk); #1;
        check("t4 decoder net +2", 32'(dec_cnt - dec0), 32'd2);

        // Sign reversal written while at phase 11
        wr(ADDR_PERIOD, 16'd4);
        wr(ADDR_STEPS, 16'd3);
        w = w_edge;
        push_cycle(1'b0, w, 4);
        repeat (8) @(posedge clk);
        wr(ADDR_STEPS, 16'hFFFE);
        push_cycle(1'b1, w + 16, 4);
        push_cycle(1'b1, w + 32, 4);
        wait_idle("t5 idle", 100);
        check("t5 remaining end", 32'(readdata), 32'd0);

        // Write landing on a completion edge
        wr(ADDR_STEPS, 16'd1);
        w = w_edge;
        push_cycle(1'b0, w, 4);
        repeat (14) @(posedge clk);
        wr(ADDR_STEPS, 16'd2);
        check("t6 write wins", 32'(readdata), 32'd2);
        push_cycle(1'b0, w + 16, 4);
        push_cycle(1'b0, w + 32, 4);
        wait_idle("t6 idle", 100);
        check("t6 remaining end", 32'(readdata), 32'd0);

        // Reset at phase 11 during STEPS=+4
        wr(ADDR_STEPS, 16'd4);
        w = w_edge;
        d0 = done_cnt;
        push_ab(2'b01, w + 4);
        push_ab(2'b11, w + 8);
        push_ab(2'b00, w + 10);
        repeat (8) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t7 ab after reset", 32'({quad_a, quad_b}), 32'd0);
        check("t7 busy after reset", 32'(busy), 32'd0);
        check("t7 done after reset", 32'(done), 32'd0);
        addr = ADDR_STEPS; #1;
        check("t7 remaining after reset", 32'(readdata), 32'd0);
        addr = ADDR_PERIOD; #1;
        check("t7 period after reset", 32'(readdata), 32'd50);
        repeat (3) @(posedge clk);
        #1;
        check("t7 no done pulse", 32'(done_cnt - d0), 32'd0);
        check("queue drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
